// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic processing element with a double-buffered weight,
// valid-tagged activation and partial-sum pipelines, and optional saturating accumulation.
module systolic_pe_ws #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_shift_en,
    input  logic [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0] w_out,
    input  logic              w_swap,
    output logic              weight_valid,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    input  logic              sat_clr,
    output logic              sat_flag
);

    localparam logic [0:0] W_EMPTY = 1'b0;
    localparam logic [0:0] W_READY = 1'b1;

    generate
        if (ACC_W < 2 * DATA_W) begin : g_width_check
            $error("systolic_pe_ws: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic [0:0]              w_state;
    logic [DATA_W-1:0]       shadow;
    logic [DATA_W-1:0]       active;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   base_ext;
    logic signed [ACC_W:0]   sum;
    logic [ACC_W-1:0]        next_psum;
    logic                    sat_event;
    logic                    any_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_EMPTY;
        end else if (w_swap) begin
            w_state <= W_READY;
        end
    end

    assign weight_valid = (w_state == W_READY);

    // Swap copies the pre-edge shadow, so a simultaneous shift never leaks into active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (w_shift_en) begin
                shadow <= w_in;
            end
            if (w_swap) begin
                active <= shadow;
            end
        end
    end

    assign w_out = shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_out       <= '0;
            act_valid_out <= 1'b0;
        end else begin
            act_out       <= act_in;
            act_valid_out <= act_valid_in;
        end
    end

    assign any_valid = act_valid_in | psum_valid_in;

    // One guard bit above ACC_W exposes overflow as a mismatch of the top two bits.
    always_comb begin
        prod = '0;
        if (act_valid_in && weight_valid) begin
            prod = $signed(act_in) * $signed(active);
        end
        prod_ext  = {{(ACC_W + 1 - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
        base_ext  = '0;
        if (psum_valid_in) begin
            base_ext = {psum_in[ACC_W-1], psum_in};
        end
        sum       = base_ext + prod_ext;
        sat_event = 1'b0;
        next_psum = sum[ACC_W-1:0];
        if (SAT_EN && (sum[ACC_W] != sum[ACC_W-1])) begin
            sat_event = 1'b1;
            if (sum[ACC_W]) begin
                next_psum = {1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                next_psum = {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else begin
            psum_valid_out <= any_valid;
            if (any_valid) begin
                psum_out <= next_psum;
            end
        end
    end

    // A saturation in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (sat_event) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_pe_ws.sv
// Self-checking bench for systolic_pe_ws: a scoreboard driven by a behavioural model,
// plus a wrapping instance and a three-PE weight column.
module tb_systolic_pe_ws;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk;
    logic        rst;
    logic        w_shift_en;
    logic [15:0] w_in;
    logic        w_swap;
    logic [15:0] act_in;
    logic        act_valid_in;
    logic [31:0] psum_in;
    logic        psum_valid_in;
    logic        sat_clr;

    logic [15:0] w_out;
    logic        weight_valid;
    logic [15:0] act_out;
    logic        act_valid_out;
    logic [31:0] psum_out;
    logic        psum_valid_out;
    logic        sat_flag;

    logic [15:0] wr_w_out;
    logic        wr_weight_valid;
    logic [15:0] wr_act_out;
    logic        wr_act_valid_out;
    logic [31:0] wr_psum_out;
    logic        wr_psum_valid_out;
    logic        wr_sat_flag;

    logic [15:0] act_mid;
    logic        act_v_mid;
    logic [15:0] m_w_out;
    logic        m_weight_valid;
    logic [15:0] m_act_out;
    logic        m_act_valid_out;
    logic [31:0] m_psum_out;
    logic        m_psum_valid_out;
    logic        m_sat_flag;

    logic [15:0] act_bot;
    logic        act_v_bot;
    logic [15:0] b_w_out;
    logic        b_weight_valid;
    logic [15:0] b_act_out;
    logic        b_act_valid_out;
    logic [31:0] b_psum_out;
    logic        b_psum_valid_out;
    logic        b_sat_flag;

    int total;
    int bad;

    typedef struct {
        logic [31:0] psum;
        logic        pv;
        logic [15:0] act;
        logic        av;
        logic        sat;
        logic        wv;
        logic [15:0] wout;
    } exp_t;

    exp_t sb[$];

    longint mdl_shadow;
    longint mdl_active;
    bit     mdl_ready;
    logic [31:0] mdl_psum;
    bit     mdl_sat;

    systolic_pe_ws #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .w_shift_en(w_shift_en), .w_in(w_in), .w_out(w_out),
        .w_swap(w_swap), .weight_valid(weight_valid),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(act_out), .act_valid_out(act_valid_out),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .sat_clr(sat_clr), .sat_flag(sat_flag)
    );

    systolic_pe_ws #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst),
        .w_shift_en(w_shift_en), .w_in(w_in), .w_out(wr_w_out),
        .w_swap(w_swap), .weight_valid(wr_weight_valid),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(wr_act_out), .act_valid_out(wr_act_valid_out),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .psum_out(wr_psum_out), .psum_valid_out(wr_psum_valid_out),
        .sat_clr(sat_clr), .sat_flag(wr_sat_flag)
    );

    systolic_pe_ws #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b1)) pe_mid (
        .clk(clk), .rst(rst),
        .w_shift_en(w_shift_en), .w_in(w_out), .w_out(m_w_out),
        .w_swap(w_swap), .weight_valid(m_weight_valid),
        .act_in(act_mid), .act_valid_in(act_v_mid),
        .act_out(m_act_out), .act_valid_out(m_act_valid_out),
        .psum_in(psum_out), .psum_valid_in(psum_valid_out),
        .psum_out(m_psum_out), .psum_valid_out(m_psum_valid_out),
        .sat_clr(sat_clr), .sat_flag(m_sat_flag)
    );

    systolic_pe_ws #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b1)) pe_bot (
        .clk(clk), .rst(rst),
        .w_shift_en(w_shift_en), .w_in(m_w_out), .w_out(b_w_out),
        .w_swap(w_swap), .weight_valid(b_weight_valid),
        .act_in(act_bot), .act_valid_in(act_v_bot),
        .act_out(b_act_out), .act_valid_out(b_act_valid_out),
        .psum_in(m_psum_out), .psum_valid_in(m_psum_valid_out),
        .psum_out(b_psum_out), .psum_valid_out(b_psum_valid_out),
        .sat_clr(sat_clr), .sat_flag(b_sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        mdl_shadow = 0;
        mdl_active = 0;
        mdl_ready  = 1'b0;
        mdl_psum   = '0;
        mdl_sat    = 1'b0;
        sb.delete();
    endtask

    // Push the model's prediction, clock once, then pop and compare against the DUT.
    task automatic cycle(input string tag);
        exp_t   e;
        longint prod;
        longint base;
        longint s;
        bit     sat_evt;
        prod    = (act_valid_in && mdl_ready) ? longint'($signed(act_in)) * mdl_active : 0;
        base    = psum_valid_in ? longint'($signed(psum_in)) : 0;
        s       = base + prod;
        sat_evt = 1'b0;
        if (act_valid_in || psum_valid_in) begin
            if (s > MAXV) begin
                mdl_psum = 32'h7FFFFFFF;
                sat_evt  = 1'b1;
            end else if (s < MINV) begin
                mdl_psum = 32'h80000000;
                sat_evt  = 1'b1;
            end else begin
                mdl_psum = s[31:0];
            end
        end
        if (sat_evt) mdl_sat = 1'b1;
        else if (sat_clr) mdl_sat = 1'b0;
        if (w_swap) begin
            mdl_active = mdl_shadow;
            mdl_ready  = 1'b1;
        end
        if (w_shift_en) mdl_shadow = longint'($signed(w_in));
        e.psum = mdl_psum;
        e.pv   = act_valid_in | psum_valid_in;
        e.act  = act_in;
        e.av   = act_valid_in;
        e.sat  = mdl_sat;
        e.wv   = mdl_ready;
        e.wout = mdl_shadow[15:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (psum_out !== e.psum) begin
            bad++;
            $display("[TB] FAIL %s.psum_out actual=%h required=%h", tag, psum_out, e.psum);
        end
        total++;
        if (psum_valid_out !== e.pv) begin
            bad++;
            $display("[TB] FAIL %s.psum_valid_out actual=%b required=%b", tag, psum_valid_out, e.pv);
        end
        total++;
        if (act_out !== e.act) begin
            bad++;
            $display("[TB] FAIL %s.act_out actual=%h required=%h", tag, act_out, e.act);
        end
        total++;
        if (act_valid_out !== e.av) begin
            bad++;
            $display("[TB] FAIL %s.act_valid_out actual=%b required=%b", tag, act_valid_out, e.av);
        end
        total++;
        if (sat_flag !== e.sat) begin
            bad++;
            $display("[TB] FAIL %s.sat_flag actual=%b required=%b", tag, sat_flag, e.sat);
        end
        total++;
        if (weight_valid !== e.wv) begin
            bad++;
            $display("[TB] FAIL %s.weight_valid actual=%b required=%b", tag, weight_valid, e.wv);
        end
        total++;
        if (w_out !== e.wout) begin
            bad++;
            $display("[TB] FAIL %s.w_out actual=%h required=%h", tag, w_out, e.wout);
        end
    endtask

    task automatic step(input logic sh, input logic [15:0] win, input logic sw,
                        input logic [15:0] a, input logic av,
                        input logic [31:0] p, input logic pv,
                        input logic clr, input string tag);
        w_shift_en    = sh;
        w_in          = win;
        w_swap        = sw;
        act_in        = a;
        act_valid_in  = av;
        psum_in       = p;
        psum_valid_in = pv;
        sat_clr       = clr;
        cycle(tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({psum_out, psum_valid_out, act_out, act_valid_out, sat_flag, weight_valid, w_out} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs actual=%h/%b/%h/%b/%b/%b/%h required=all zero",
                     psum_out, psum_valid_out, act_out, act_valid_out, sat_flag, weight_valid, w_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b1, 16'd5, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "basic_shift");
        total++;
        if (weight_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_wv_pre actual=%b required=0", weight_valid);
        end
        step(1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "basic_swap");
        total++;
        if (weight_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_wv_post actual=%b required=1", weight_valid);
        end
        step(1'b0, 16'd0, 1'b0, 16'd3, 1'b1, 32'd10, 1'b1, 1'b0, "basic_mac");
        total++;
        if (psum_out !== 32'd25 || psum_valid_out !== 1'b1 || act_out !== 16'd3 || act_valid_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_mac_plan actual=%0d/%b/%0d/%b required=25/1/3/1",
                     psum_out, psum_valid_out, act_out, act_valid_out);
        end
    endtask

    task automatic test_swap_same_cycle();
        step(1'b1, 16'd7, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "swap_shift7");
        step(1'b0, 16'd0, 1'b1, 16'd2, 1'b1, 32'd0, 1'b1, 1'b0, "swap_compute");
        total++;
        if (psum_out !== 32'd10) begin
            bad++;
            $display("[TB] FAIL swap_old_weight actual=%0d required=10", psum_out);
        end
        step(1'b0, 16'd0, 1'b0, 16'd2, 1'b1, 32'd0, 1'b1, 1'b0, "swap_next");
        total++;
        if (psum_out !== 32'd14) begin
            bad++;
            $display("[TB] FAIL swap_new_weight actual=%0d required=14", psum_out);
        end
    endtask

    task automatic test_saturate();
        step(1'b1, 16'd100, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "sat_shift100");
        step(1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "sat_swap100");
        step(1'b0, 16'd0, 1'b0, 16'd100, 1'b1, 32'h7FFFFFF0, 1'b1, 1'b0, "sat_pos");
        total++;
        if (psum_out !== 32'h7FFFFFFF || sat_flag !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_pos_clamp actual=%h/%b required=7fffffff/1", psum_out, sat_flag);
        end
        total++;
        if (wr_psum_out !== 32'h80002700 || wr_sat_flag !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_pos actual=%h/%b required=80002700/0", wr_psum_out, wr_sat_flag);
        end
        step(1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "sat_shift1");
        step(1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "sat_swap1");
        step(1'b0, 16'd0, 1'b0, 16'hFFFF, 1'b1, 32'h80000000, 1'b1, 1'b0, "sat_neg");
        total++;
        if (psum_out !== 32'h80000000) begin
            bad++;
            $display("[TB] FAIL sat_neg_clamp actual=%h required=80000000", psum_out);
        end
        total++;
        if (wr_psum_out !== 32'h7FFFFFFF) begin
            bad++;
            $display("[TB] FAIL wrap_neg actual=%h required=7fffffff", wr_psum_out);
        end
        step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b1, "sat_clear");
        total++;
        if (sat_flag !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sat_clear actual=%b required=0", sat_flag);
        end
        step(1'b0, 16'd0, 1'b0, 16'hFFFF, 1'b1, 32'h80000000, 1'b1, 1'b1, "sat_set_wins");
        total++;
        if (sat_flag !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_set_wins actual=%b required=1", sat_flag);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 16'd0, 1'b0, 16'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "wrap_max");
        total++;
        if (wr_psum_out !== 32'h80000000 || wr_sat_flag !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_max actual=%h/%b required=80000000/0", wr_psum_out, wr_sat_flag);
        end
    endtask

    task automatic test_empty_weight();
        rst = 1'b0;
        #2;
        total++;
        if (weight_valid !== 1'b0 || psum_valid_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL empty_reset actual=%b/%b required=0/0", weight_valid, psum_valid_out);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 16'd0, 1'b0, 16'd9, 1'b1, 32'd42, 1'b1, 1'b0, "empty_pass");
        total++;
        if (psum_out !== 32'd42) begin
            bad++;
            $display("[TB] FAIL empty_pass actual=%0d required=42", psum_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "empty_idle");
            total++;
            if (psum_out !== 32'd42 || psum_valid_out !== 1'b0) begin
                bad++;
                $display("[TB] FAIL empty_hold actual=%0d/%b required=42/0", psum_out, psum_valid_out);
            end
        end
    endtask

    task automatic test_column_chain();
        step(1'b1, 16'd11, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "chain_s11");
        step(1'b1, 16'd22, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "chain_s22");
        step(1'b1, 16'd33, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "chain_s33");
        total++;
        if (m_w_out !== 16'd22 || b_w_out !== 16'd11) begin
            bad++;
            $display("[TB] FAIL chain_shadows actual=%0d/%0d required=22/11", m_w_out, b_w_out);
        end
        step(1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, "chain_swap");
        act_mid   = 16'd1;
        act_v_mid = 1'b1;
        act_bot   = 16'd1;
        act_v_bot = 1'b1;
        step(1'b0, 16'd0, 1'b0, 16'd1, 1'b1, 32'd0, 1'b0, 1'b0, "chain_probe");
        total++;
        if (psum_out !== 32'd33 || m_psum_out !== 32'd22 || b_psum_out !== 32'd11) begin
            bad++;
            $display("[TB] FAIL chain_weights actual=%0d/%0d/%0d required=33/22/11",
                     psum_out, m_psum_out, b_psum_out);
        end
        act_v_bot = 1'b0;
        step(1'b0, 16'd0, 1'b0, 16'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, "chain_ovf");
        total++;
        if (sat_flag !== 1'b1 || m_psum_valid_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL chain_pre_reset actual=%b/%b required=1/1", sat_flag, m_psum_valid_out);
        end
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({psum_valid_out, act_valid_out, sat_flag, weight_valid,
             m_psum_valid_out, m_act_valid_out, m_weight_valid,
             b_psum_valid_out, b_weight_valid} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL chain_async_reset actual=%b%b%b%b%b%b%b%b%b required=000000000",
                     psum_valid_out, act_valid_out, sat_flag, weight_valid,
                     m_psum_valid_out, m_act_valid_out, m_weight_valid,
                     b_psum_valid_out, b_weight_valid);
        end
        model_reset();
        act_v_mid     = 1'b0;
        act_valid_in  = 1'b0;
        psum_valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b0;
        total         = 0;
        bad           = 0;
        w_shift_en    = 1'b0;
        w_in          = '0;
        w_swap        = 1'b0;
        act_in        = '0;
        act_valid_in  = 1'b0;
        psum_in       = '0;
        psum_valid_in = 1'b0;
        sat_clr       = 1'b0;
        act_mid       = '0;
        act_v_mid     = 1'b0;
        act_bot       = '0;
        act_v_bot     = 1'b0;
        test_reset();
        test_basic();
        test_swap_same_cycle();
        test_saturate();
        test_wrap();
        test_empty_weight();
        test_column_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
